// File: rtl/rx_byte_packer_pkg.sv
// Shared types and word-layout constants for the rx byte packer.
package rx_byte_packer_pkg;

  localparam int unsigned WORD_W = 64;

  // Header word field offsets
  localparam int unsigned LEN_LSB  = 0;
  localparam int unsigned RATE_LSB = 16;

  // Status word field offsets
  localparam int unsigned FCS_BIT   = 0;
  localparam int unsigned OVF_BIT   = 1;
  localparam int unsigned ABORT_BIT = 2;
  localparam int unsigned CNT_LSB   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_FLUSH,
    ST_STATUS,
    ST_HDR
  } state_t;

  function automatic logic [WORD_W-1:0] hdr_word(input logic [15:0] len,
                                                 input logic [7:0]  rate);
    logic [WORD_W-1:0] w;
    w = '0;
    w[LEN_LSB +: 16] = len;
    w[RATE_LSB +: 8] = rate;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] status_word(input logic        fcs,
                                                    input logic        ovf,
                                                    input logic        abort,
                                                    input logic [15:0] cnt);
    logic [WORD_W-1:0] w;
    w = '0;
    w[FCS_BIT]       = fcs;
    w[OVF_BIT]       = ovf;
    w[ABORT_BIT]     = abort;
    w[CNT_LSB +: 16] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/rx_byte_packer_fifo.sv
// First-word-fall-through FIFO; head entry is visible while not empty.
module rx_word_fifo #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned W     = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because reads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/rx_byte_packer.sv
// Packs receiver bytes into header/payload/status 64-bit words on a stream.
module rx_byte_packer
  import rx_byte_packer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FIFO_AW    = 6
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        enable,
  input  logic        pkt_header_valid_strobe,
  input  logic        ht_unsupport,
  input  logic [7:0]  pkt_rate,
  input  logic [15:0] pkt_len,
  input  logic        byte_out_strobe,
  input  logic [7:0]  byte_out,
  input  logic        fcs_out_strobe,
  input  logic        fcs_ok,
  output logic [63:0] m_tdata,
  output logic        m_tlast,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [15:0] overflow_count
);

  state_t              r_state;
  logic [15:0]         r_len;
  logic [7:0]          r_rate;
  logic [WORD_W-1:0]   r_word;
  logic [2:0]          r_byte_idx;
  logic [15:0]         r_byte_cnt;
  logic                r_fcs_ok;
  logic                r_ovf;
  logic                r_abort;
  logic                r_pend;
  logic [15:0]         r_pkt_cnt;
  logic [15:0]         r_ovf_cnt;

  logic                w_push;
  logic                w_push_last;
  logic [WORD_W-1:0]   w_push_data;
  logic [WORD_W:0]     w_fifo_out;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  logic                w_drop;
  logic                w_stray;
  logic                w_stat_stall;
  logic                w_hdr_ok;
  logic [2:0]          w_idx_inc;
  logic [2:0]          w_idx_after;
  logic [1:0]          w_ovf_inc;
  logic [16:0]         w_ovf_sum;

  rx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .W     (WORD_W + 1)
  ) u_fifo (
    .clk     (s00_axi_aclk),
    .rst_n   (s00_axi_aresetn),
    .i_push  (w_push),
    .i_data  ({w_push_last, w_push_data}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign m_tvalid       = !w_fifo_empty;
  assign m_tdata        = w_fifo_out[WORD_W-1:0];
  assign m_tlast        = w_fifo_out[WORD_W];
  assign busy           = (r_state != ST_IDLE);
  assign pkt_count      = r_pkt_cnt;
  assign overflow_count = r_ovf_cnt;

  assign w_pop        = m_tvalid && m_tready;
  assign w_hdr_ok     = enable && !ht_unsupport;
  assign w_idx_inc    = r_byte_idx + 3'd1;
  assign w_idx_after  = byte_out_strobe ? w_idx_inc : r_byte_idx;
  assign w_stat_stall = (r_state == ST_STATUS) && w_fifo_full && !w_pop;
  assign w_drop       = w_push && w_fifo_full && !w_pop;
  assign w_stray      = byte_out_strobe &&
                        ((r_state == ST_HDR) || (r_state == ST_FLUSH) || (r_state == ST_STATUS));
  assign w_ovf_inc    = {1'b0, w_drop} + {1'b0, w_stray};
  assign w_ovf_sum    = {1'b0, r_ovf_cnt} + 17'(w_ovf_inc);

  // Select the word (if any) pushed this cycle; at most one per cycle.
  always_comb begin
    w_push      = 1'b0;
    w_push_last = 1'b0;
    w_push_data = '0;
    case (r_state)
      ST_HDR: begin
        w_push      = 1'b1;
        w_push_data = hdr_word(r_len, r_rate);
      end
      ST_DATA: begin
        if (byte_out_strobe && (r_byte_idx == 3'd7)) begin
          w_push      = 1'b1;
          w_push_data = {byte_out, r_word[55:0]};
        end
      end
      ST_FLUSH: begin
        w_push      = 1'b1;
        w_push_data = r_word;
      end
      ST_STATUS: begin
        // Status is withheld rather than dropped while the FIFO is full.
        w_push      = !w_stat_stall;
        w_push_last = 1'b1;
        w_push_data = status_word(r_fcs_ok, r_ovf, r_abort, r_byte_cnt);
      end
      default: ;
    endcase
  end

  // Packet framing state machine with counters and sticky flags
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_rate     <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
      r_byte_cnt <= '0;
      r_fcs_ok   <= 1'b0;
      r_ovf      <= 1'b0;
      r_abort    <= 1'b0;
      r_pend     <= 1'b0;
      r_pkt_cnt  <= '0;
      r_ovf_cnt  <= '0;
    end else begin
      r_ovf_cnt <= w_ovf_sum[16] ? '1 : w_ovf_sum[15:0];
      case (r_state)
        ST_IDLE: begin
          if (pkt_header_valid_strobe && w_hdr_ok) begin
            r_len   <= pkt_len;
            r_rate  <= pkt_rate;
            r_state <= ST_HDR;
          end
        end
        ST_HDR: begin
          r_byte_idx <= '0;
          r_byte_cnt <= '0;
          r_word     <= '0;
          r_fcs_ok   <= 1'b0;
          r_abort    <= 1'b0;
          r_pend     <= 1'b0;
          r_ovf      <= w_drop || byte_out_strobe;
          r_state    <= ST_DATA;
        end
        ST_DATA: begin
          if (w_drop) r_ovf <= 1'b1;
          if (byte_out_strobe) begin
            if (r_byte_idx == 3'd7) r_word <= '0;
            else                    r_word[{r_byte_idx, 3'b000} +: 8] <= byte_out;
            r_byte_idx <= w_idx_inc;
            if (r_byte_cnt != 16'hFFFF) r_byte_cnt <= r_byte_cnt + 16'd1;
          end
          if (fcs_out_strobe) begin
            r_fcs_ok <= fcs_ok;
            r_state  <= (w_idx_after != 3'd0) ? ST_FLUSH : ST_STATUS;
          end else if (pkt_header_valid_strobe) begin
            r_abort  <= 1'b1;
            r_fcs_ok <= 1'b0;
            r_pend   <= w_hdr_ok;
            if (w_hdr_ok) begin
              r_len  <= pkt_len;
              r_rate <= pkt_rate;
            end
            r_state <= (w_idx_after != 3'd0) ? ST_FLUSH : ST_STATUS;
          end
        end
        ST_FLUSH: begin
          if (w_drop || byte_out_strobe) r_ovf <= 1'b1;
          r_state <= ST_STATUS;
        end
        ST_STATUS: begin
          if (w_stat_stall) begin
            if (byte_out_strobe) r_ovf <= 1'b1;
            if (pkt_header_valid_strobe) begin
              r_abort  <= 1'b1;
              r_fcs_ok <= 1'b0;
              r_pend   <= w_hdr_ok;
              if (w_hdr_ok) begin
                r_len  <= pkt_len;
                r_rate <= pkt_rate;
              end
            end
          end else begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
            r_pend    <= 1'b0;
            r_state   <= r_pend ? ST_HDR : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_byte_packer.sv
// Directed self-checking bench for rx_byte_packer.
module tb_rx_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        pkt_header_valid_strobe = 1'b0;
  logic        ht_unsupport = 1'b0;
  logic [7:0]  pkt_rate = '0;
  logic [15:0] pkt_len = '0;
  logic        byte_out_strobe = 1'b0;
  logic [7:0]  byte_out = '0;
  logic        fcs_out_strobe = 1'b0;
  logic        fcs_ok = 1'b0;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;
  logic [15:0] overflow_count;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;
  logic [64:0] q[$];

  rx_byte_packer #(
    .FIFO_DEPTH (64),
    .FIFO_AW    (6)
  ) dut (
    .s00_axi_aclk            (clk),
    .s00_axi_aresetn         (rst_n),
    .enable                  (enable),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .ht_unsupport            (ht_unsupport),
    .pkt_rate                (pkt_rate),
    .pkt_len                 (pkt_len),
    .byte_out_strobe         (byte_out_strobe),
    .byte_out                (byte_out),
    .fcs_out_strobe          (fcs_out_strobe),
    .fcs_ok                  (fcs_ok),
    .m_tdata                 (m_tdata),
    .m_tlast                 (m_tlast),
    .m_tvalid                (m_tvalid),
    .m_tready                (m_tready),
    .busy                    (busy),
    .pkt_count               (pkt_count),
    .overflow_count          (overflow_count)
  );

  always #5 clk = ~clk;

  // Capture every accepted word midway between active edges
  always @(negedge clk) begin
    if (m_tvalid && m_tready) q.push_back({m_tlast, m_tdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [15:0] len, input logic [7:0] rate,
                          input logic ht, input logic en);
    pkt_header_valid_strobe = 1'b1;
    pkt_len      = len;
    pkt_rate     = rate;
    ht_unsupport = ht;
    enable       = en;
    tick();
    pkt_header_valid_strobe = 1'b0;
    ht_unsupport = 1'b0;
    enable       = 1'b1;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input logic ok);
    byte_out_strobe = 1'b1;
    byte_out        = b;
    fcs_out_strobe  = last;
    fcs_ok          = ok;
    tick();
    byte_out_strobe = 1'b0;
    fcs_out_strobe  = 1'b0;
    fcs_ok          = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [63:0] data, input logic last);
    logic [64:0] v;
    int unsigned w;
    w = 0;
    while (q.size() == 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (q.size() == 0) begin
      check_val($sformatf("%s_timeout", tag), 64'(q.size()), 64'd1);
    end else begin
      v = q.pop_front();
      check_val(tag, v[63:0], data);
      check_val($sformatf("%s_last", tag), 64'(v[64]), 64'(last));
    end
  endtask

  initial begin
    logic [63:0] e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_tvalid", 64'(m_tvalid), 64'd0);
    check_val("rst_tdata", m_tdata, 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_pkt_count", 64'(pkt_count), 64'd0);
    check_val("rst_ovf_count", 64'(overflow_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Short packet with padded final word
    send_hdr(16'd5, 8'h0B, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), i == 5, 1'b1);
    repeat (4) tick();
    check_val("t1_busy", 64'(busy), 64'd0);
    check_val("t1_pkt_count", 64'(pkt_count), 64'd1);
    expect_word("t1_hdr", 64'h0000_0000_000B_0005, 1'b0);
    expect_word("t1_data", 64'h0000_0005_0403_0201, 1'b0);
    expect_word("t1_status", 64'h0000_0000_0005_0001, 1'b1);
    tick();

    // FCS coincident with the byte completing the last word
    send_hdr(16'd16, 8'h0D, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), i == 15, 1'b1);
    repeat (4) tick();
    check_val("t2_pkt_count", 64'(pkt_count), 64'd2);
    expect_word("t2_hdr", 64'h0000_0000_000D_0010, 1'b0);
    expect_word("t2_w0", 64'h1716_1514_1312_1110, 1'b0);
    expect_word("t2_w1", 64'h1F1E_1D1C_1B1A_1918, 1'b0);
    expect_word("t2_status", 64'h0000_0000_0010_0001, 1'b1);
    repeat (3) tick();
    check_val("t2_no_extra", 64'(q.size()), 64'd0);

    // Abort by a new header, then the new packet completes
    send_hdr(16'd3, 8'h01, 1'b0, 1'b1);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b0);
    send_hdr(16'd2, 8'h02, 1'b0, 1'b1);
    repeat (2) tick();
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1);
    repeat (4) tick();
    check_val("t3_pkt_count", 64'(pkt_count), 64'd4);
    expect_word("t3_hdrA", 64'h0000_0000_0001_0003, 1'b0);
    expect_word("t3_padA", 64'h0000_0000_00CC_BBAA, 1'b0);
    expect_word("t3_statA", 64'h0000_0000_0003_0004, 1'b1);
    expect_word("t3_hdrB", 64'h0000_0000_0002_0002, 1'b0);
    expect_word("t3_dataB", 64'h0000_0000_0000_2211, 1'b0);
    expect_word("t3_statB", 64'h0000_0000_0002_0001, 1'b1);
    tick();

    // Rejected headers and idle bytes produce nothing
    send_hdr(16'd7, 8'h03, 1'b1, 1'b1);
    check_val("t4_busy_ht", 64'(busy), 64'd0);
    send_byte(8'h55, 1'b1, 1'b1);
    send_hdr(16'd7, 8'h03, 1'b0, 1'b0);
    check_val("t4_busy_dis", 64'(busy), 64'd0);
    repeat (3) tick();
    check_val("t4_no_words", 64'(q.size()), 64'd0);
    check_val("t4_pkt_count", 64'(pkt_count), 64'd4);
    check_val("t4_ovf_count", 64'(overflow_count), 64'd0);

    // Consumer stalled through a 600-byte packet
    m_tready = 1'b0;
    send_hdr(16'd600, 8'h0C, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) send_byte(8'(i), i == 599, 1'b1);
    repeat (3) tick();
    check_val("t5_ovf_count", 64'(overflow_count), 64'd12);
    check_val("t5_busy_stall", 64'(busy), 64'd1);
    check_val("t5_pkt_count_stall", 64'(pkt_count), 64'd4);
    check_val("t5_nothing_out", 64'(q.size()), 64'd0);
    m_tready = 1'b1;
    expect_word("t5_hdr", 64'h0000_0000_000C_0258, 1'b0);
    for (int k = 0; k < 63; k++) begin
      for (int j = 0; j < 8; j++) e[8*j +: 8] = 8'(8*k + j);
      expect_word($sformatf("t5_w%0d", k), e, 1'b0);
    end
    expect_word("t5_status", 64'h0000_0000_0258_0003, 1'b1);
    tick();
    repeat (3) tick();
    check_val("t5_pkt_count", 64'(pkt_count), 64'd5);
    check_val("t5_busy_end", 64'(busy), 64'd0);
    check_val("t5_no_extra", 64'(q.size()), 64'd0);

    // Reset in the middle of a packet, then a clean packet
    m_tready = 1'b0;
    send_hdr(16'd10, 8'h04, 1'b0, 1'b1);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    check_val("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    check_val("t6_rst_tdata", m_tdata, 64'd0);
    check_val("t6_rst_tlast", 64'(m_tlast), 64'd0);
    check_val("t6_rst_busy", 64'(busy), 64'd0);
    check_val("t6_rst_pkt_count", 64'(pkt_count), 64'd0);
    check_val("t6_rst_ovf_count", 64'(overflow_count), 64'd0);
    rst_n = 1'b1;
    tick();
    m_tready = 1'b1;
    tick();
    check_val("t6_no_stale", 64'(q.size()), 64'd0);
    send_hdr(16'd2, 8'h05, 1'b0, 1'b1);
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b1, 1'b1);
    repeat (4) tick();
    check_val("t6_pkt_count", 64'(pkt_count), 64'd1);
    expect_word("t6_hdr", 64'h0000_0000_0005_0002, 1'b0);
    expect_word("t6_data", 64'h0000_0000_0000_A2A1, 1'b0);
    expect_word("t6_status", 64'h0000_0000_0002_0001, 1'b1);
    tick();
    repeat (3) tick();
    check_val("t6_no_extra", 64'(q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rx_byte_packer.md
Name: rx_byte_packer

Overview:
- Sits directly downstream of the OFDM receiver core. Consumes its byte stream, header strobe and FCS result.
- Packs each received packet into 64-bit words framed as: header word, payload words, status word.
- Words are buffered in an internal FIFO and presented on a valid/ready stream toward the rx DMA/interface logic.
- Absorbs the core's bursty, unthrottleable output; detects and counts overflow and aborted packets.

Parameters:
- FIFO_DEPTH, 64, number of 64-bit words buffered (power of two, minimum 8)
- FIFO_AW, 6, address width; equals log2(FIFO_DEPTH)

Ports:
- s00_axi_aclk  in  1  clock
- s00_axi_aresetn  in  1  reset; asynchronous, active-low
- enable  in  1  when 0, new headers are ignored; a packet in progress completes normally
- pkt_header_valid_strobe  in  1  one-cycle pulse; header fields valid
- ht_unsupport  in  1  sampled with the header strobe
- pkt_rate  in  8  rate code, sampled with the header strobe
- pkt_len  in  16  payload length in bytes, sampled with the header strobe
- byte_out_strobe  in  1  payload byte valid
- byte_out  in  8  payload byte
- fcs_out_strobe  in  1  end of packet; fcs_ok is valid in the same cycle
- fcs_ok  in  1  FCS check result
- m_tdata  out  64  output word
- m_tlast  out  1  high on the status word
- m_tvalid  out  1  output word valid
- m_tready  in  1  consumer accepts the word when m_tvalid and m_tready are both high
- busy  out  1  state machine not in IDLE
- pkt_count  out  16  packets fully emitted (status word pushed); wraps at 65535
- overflow_count  out  16  words dropped on a full FIFO; saturates at 65535

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE.

Word formats:
- Header word: [15:0] pkt_len, [23:16] pkt_rate, rest 0.
- Payload words: bytes little-endian; the first byte of each word goes in [7:0]. A partial final word is zero-padded.
- Status word: [0] fcs_ok, [1] overflow occurred in this packet, [2] aborted, [31:16] bytes received, rest 0. m_tlast=1.

State machine (IDLE, DATA, FLUSH, STATUS, HDR):
- IDLE: on a header strobe with enable=1 and ht_unsupport=0, latch rate/len and go to HDR. Otherwise stay in IDLE. Byte and fcs strobes in IDLE are ignored.
- HDR: push the header word; clear byte index, byte count and sticky flags; go to DATA.
- DATA: on each byte strobe, write the byte into lane byte_idx and increment the 16-bit byte count (saturating).
  - When lane 7 is written, push the word in the same cycle and wrap byte_idx to 0.
- DATA, fcs_out_strobe: latch fcs_ok. Go to FLUSH if byte_idx≠0, else go to STATUS.
  - A byte strobe in the same cycle is processed first and counted.
  - If that byte completes a word, the word is pushed and the next state is STATUS.
- FLUSH: push the zero-padded partial word; go to STATUS.
- STATUS: push the status word, increment pkt_count, go to IDLE.
- Abort: a header strobe in DATA (no FCS seen) records a pending header and sets aborted=1 with fcs_ok=0.
  - Sequence is FLUSH (if needed), then STATUS, then HDR with the pending header, skipping IDLE.
  - If ht_unsupport=1 or enable=0 at the abort strobe, no pending header is kept and the block returns to IDLE after STATUS.
- Rate and ordering: at most one FIFO push per cycle. FLUSH, STATUS and HDR each take exactly one cycle. Byte strobes arriving in those states are dropped and counted as overflow.
- FIFO full on push: the word is dropped, overflow_count increments (saturating) and the packet's sticky overflow bit is set.
  - Exception: a status word is never dropped. If the FIFO is full in STATUS, the FSM stalls in STATUS until space is available.
  - A header strobe during that stall is handled as an abort.
- FIFO timing: first-word-fall-through with registered output. A word pushed in cycle N appears with m_tvalid=1 in cycle N+1.
  - Simultaneous push and pop when full is permitted and is not an overflow.
- Reset mid-packet: asynchronous clear of everything; no status word is emitted for the interrupted packet.

Decomposition:
- Package rx_byte_packer_pkg holds:
  - the state enum;
  - header field offsets (LEN_LSB=0, RATE_LSB=16);
  - status field offsets (FCS_BIT=0, OVF_BIT=1, ABORT_BIT=2, CNT_LSB=16);
  - the word width constant 64.
- Sub-module rx_word_fifo: synchronous FWFT FIFO of 65 bits (data + last), with full/empty flags and push/pop.

Test Plan:
- Header (len=5, rate=0x0B), 5 bytes 01..05, fcs_ok=1 → three words: 0x0000_0000_000B_0005; 0x0000_0005_0403_0201; status 0x0005_0001 with tlast. pkt_count=1.
- len=16, 16 bytes, fcs_out_strobe coincident with the 16th byte → header, two full words, status 0x0010_0001. No padded word.
- m_tready=0 throughout a 600-byte packet (FIFO_DEPTH=64) → 63 words stored, later words dropped, overflow_count incremented per drop. Status word emitted once the consumer drains, with bit1=1.
- Header A, 3 bytes, then header B with no FCS → A's padded word, status 0x0003_0004, then B's header word. B then completes normally.
- Header with ht_unsupport=1, or with enable=0 → no words emitted, busy stays 0.
- Assert s00_axi_aresetn low mid-packet, then send a new packet → all outputs 0 during reset. Only the new packet's words appear, with correct framing.
